// File: rtl/rvee_trap_pkg.sv
// rvee_trap_pkg: shared FSM states, interrupt cause codes and priority order for the trap sequencer.
package rvee_trap_pkg;
  typedef enum logic [2:0] {IDLE, FLUSH, COMMIT, REDIRECT, MRET} state_t;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;
  localparam logic [3:0] IRQ_PRIO [3] = '{IRQ_MEI, IRQ_MSI, IRQ_MTI};
  // Walk from lowest to highest priority so the highest pending cause wins.
  function automatic logic [3:0] irq_pick(input logic [15:0] pend);
    irq_pick = '0;
    for (int i = 2; i >= 0; i--) if (pend[IRQ_PRIO[i]]) irq_pick = IRQ_PRIO[i];
  endfunction
endpackage

// File: rtl/rvee_trap_sync.sv
// rvee_sync: STAGES-deep single-bit synchronizer with asynchronous reset.
module rvee_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk or posedge rst)
    if (rst) r <= '0;
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/rvee_trap.sv
// rvee_trap: arbitrates exceptions vs machine interrupts, flushes, strobes CSR trap entry and redirects fetch.
module rvee_trap
  import rvee_trap_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            exc_has_tval,
  input  logic            retire_valid,
  input  logic [XLEN-1:0] next_pc,
  input  logic            mret,
  input  logic            mie,
  input  logic            msie_en,
  input  logic            mtie_en,
  input  logic            meie_en,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            irq_msip,
  input  logic            irq_mtip,
  input  logic            irq_meip,
  output logic            flush_req,
  input  logic            flush_ack,
  output logic            exception,
  output logic            irq,
  output logic [XLEN-2:0] n_cause,
  output logic [XLEN-1:0] trap_pc,
  output logic            we_tval,
  output logic [XLEN-1:0] n_tval,
  output logic            mret_restore,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);
  logic s_msip, s_mtip, s_meip;
  rvee_sync #(.STAGES(SYNC_STAGES)) u_msip (.clk(clk), .rst(rst), .d(irq_msip), .q(s_msip));
  rvee_sync #(.STAGES(SYNC_STAGES)) u_mtip (.clk(clk), .rst(rst), .d(irq_mtip), .q(s_mtip));
  rvee_sync #(.STAGES(SYNC_STAGES)) u_meip (.clk(clk), .rst(rst), .d(irq_meip), .q(s_meip));
  logic [15:0] pend;
  always_comb begin
    pend = '0;
    pend[IRQ_MSI] = s_msip & msie_en;
    pend[IRQ_MTI] = s_mtip & mtie_en;
    pend[IRQ_MEI] = s_meip & meie_en;
  end
  logic take_irq, take_trap;
  assign take_irq = retire_valid & mie & |pend;
  assign take_trap = exc_valid | (!mret & take_irq);
  state_t state, next;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = exc_valid ? FLUSH : mret ? MRET : take_irq ? FLUSH : IDLE;
      FLUSH:   next = flush_ack ? COMMIT : FLUSH;
      COMMIT:  next = REDIRECT;
      default: next = IDLE;
    endcase
  end
  logic            l_irq, l_we;
  logic [3:0]      l_cause;
  logic [XLEN-1:0] l_pc, l_tval;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      l_irq <= 1'b0;
      l_we <= 1'b0;
      l_cause <= '0;
      l_pc <= '0;
      l_tval <= '0;
    end else if (state == IDLE && take_trap) begin
      l_irq <= !exc_valid;
      l_we <= 1'b1;
      l_cause <= exc_valid ? exc_cause : irq_pick(pend);
      l_pc <= exc_valid ? exc_pc : next_pc;
      l_tval <= (exc_valid && exc_has_tval) ? exc_tval : '0;
    end
  logic trap_act;
  always_comb begin
    trap_act = state inside {FLUSH, COMMIT, REDIRECT};
    flush_req = state == FLUSH;
    exception = state == COMMIT;
    we_tval = exception & l_we;
    irq = trap_act & l_irq;
    n_cause = trap_act ? (XLEN-1)'(l_cause) : '0;
    trap_pc = trap_act ? l_pc : '0;
    n_tval = trap_act ? l_tval : '0;
    mret_restore = state == MRET;
    redirect_valid = state == REDIRECT || state == MRET;
    redirect_pc = state == REDIRECT ? (mtvec & ~XLEN'(3)) : state == MRET ? mepc : '0;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_rvee_trap.sv
// tb_rvee_trap: directed plan cases plus random stimulus checked against a per-cycle expectation scoreboard.
module tb_rvee_trap;
  logic        clk = 0, rst = 1;
  logic        exc_valid, exc_has_tval, retire_valid, mret, mie, msie_en, mtie_en, meie_en;
  logic        irq_msip, irq_mtip, irq_meip, flush_ack;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval, next_pc, mtvec, mepc;
  logic        flush_req, exception, irq, we_tval, mret_restore, redirect_valid, busy;
  logic [30:0] n_cause;
  logic [31:0] trap_pc, n_tval, redirect_pc;

  rvee_trap #(.XLEN(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .exc_has_tval(exc_has_tval), .retire_valid(retire_valid),
    .next_pc(next_pc), .mret(mret), .mie(mie), .msie_en(msie_en), .mtie_en(mtie_en),
    .meie_en(meie_en), .mtvec(mtvec), .mepc(mepc), .irq_msip(irq_msip), .irq_mtip(irq_mtip),
    .irq_meip(irq_meip), .flush_req(flush_req), .flush_ack(flush_ack), .exception(exception),
    .irq(irq), .n_cause(n_cause), .trap_pc(trap_pc), .we_tval(we_tval), .n_tval(n_tval),
    .mret_restore(mret_restore), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int ack_delay = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // One entry per expected busy cycle; an empty queue means the DUT should be idle.
  typedef struct {
    bit fl, ex, rv, mr, tv, ack, irq, rd_tvec;
    logic [3:0] cause;
    logic [31:0] pc, tval;
  } ent_t;
  ent_t q[$];
  logic [2:0] hist[$];

  task automatic push_trap(input bit is_irq, input logic [3:0] cause, input logic [31:0] pc, input logic [31:0] tval);
    ent_t e;
    int d;
    d = ack_delay < 0 ? int'($urandom_range(0, 3)) : ack_delay;
    e = '{default: 0};
    e.tv = 1; e.irq = is_irq; e.cause = cause; e.pc = pc; e.tval = tval;
    for (int i = 0; i <= d; i++) begin
      e.fl = 1; e.ack = (i == d);
      q.push_back(e);
    end
    e.fl = 0; e.ack = 0; e.ex = 1;
    q.push_back(e);
    e.ex = 0; e.rv = 1; e.rd_tvec = 1;
    q.push_back(e);
  endtask

  task automatic take();
    logic [2:0] p;
    ent_t e;
    p = hist[0] & {meie_en, msie_en, mtie_en};
    if (exc_valid) push_trap(0, exc_cause, exc_pc, exc_has_tval ? exc_tval : 32'd0);
    else if (mret) begin
      e = '{default: 0};
      e.mr = 1; e.rv = 1;
      q.push_back(e);
    end else if (retire_valid && mie && p != 0)
      push_trap(1, p[2] ? 4'd11 : p[1] ? 4'd3 : 4'd7, next_pc, 32'd0);
  endtask

  task automatic step(input bit rnd);
    ent_t e;
    bit act;
    if (rnd) begin
      exc_valid = ($urandom % 8) == 0;
      exc_cause = 4'($urandom);
      exc_pc = $urandom; exc_tval = $urandom; exc_has_tval = 1'($urandom);
      retire_valid = 1'($urandom); next_pc = $urandom;
      mret = ($urandom % 10) == 0;
      mie = ($urandom % 4) != 0;
      msie_en = ($urandom % 4) != 0; mtie_en = ($urandom % 4) != 0; meie_en = ($urandom % 4) != 0;
      mtvec = $urandom; mepc = $urandom; flush_ack = 1'($urandom);
      if ($urandom % 8 == 0) irq_msip = ~irq_msip;
      if ($urandom % 8 == 0) irq_mtip = ~irq_mtip;
      if ($urandom % 8 == 0) irq_meip = ~irq_meip;
    end
    @(negedge clk);
    act = q.size() != 0;
    if (act) e = q[0];
    else e = '{default: 0};
    chk("busy", 32'(busy), 32'(act));
    chk("flush_req", 32'(flush_req), 32'(e.fl));
    chk("exception", 32'(exception), 32'(e.ex));
    chk("we_tval", 32'(we_tval), 32'(e.ex));
    chk("irq", 32'(irq), 32'(e.tv & e.irq));
    chk("n_cause", {1'b0, n_cause}, e.tv ? 32'(e.cause) : 32'd0);
    chk("trap_pc", trap_pc, e.tv ? e.pc : 32'd0);
    chk("n_tval", n_tval, e.tv ? e.tval : 32'd0);
    chk("mret_restore", 32'(mret_restore), 32'(e.mr));
    chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
    chk("redirect_pc", redirect_pc, !e.rv ? 32'd0 : e.rd_tvec ? {mtvec[31:2], 2'b00} : mepc);
    if (act) begin
      void'(q.pop_front());
      if (e.fl) flush_ack = e.ack;
    end else take();
    hist.push_back({irq_meip, irq_msip, irq_mtip});
    void'(hist.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic clr();
    {exc_valid, exc_has_tval, retire_valid, mret, mie, msie_en, mtie_en, meie_en} = '0;
    {irq_msip, irq_mtip, irq_meip, flush_ack} = '0;
    exc_cause = 0; exc_pc = 0; exc_tval = 0; next_pc = 0; mtvec = 0; mepc = 0;
  endtask

  task automatic reset_release();
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    hist = {3'b000, 3'b000};
  endtask

  initial begin
    clr();
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flush", 32'(flush_req), 0);
    chk("rst_redirect", 32'(redirect_valid), 0);
    reset_release();
    repeat (2) step(0);
    // Reset asserted while the FSM sits in FLUSH.
    ack_delay = 5;
    exc_valid = 1; exc_cause = 4'd5; exc_pc = 32'h40; exc_tval = 32'h1234; exc_has_tval = 1;
    step(0);
    exc_valid = 0;
    step(0);
    rst = 1; #1;
    chk("midrst_flush", 32'(flush_req), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_pc", trap_pc, 0);
    chk("midrst_cause", {1'b0, n_cause}, 0);
    reset_release();
    step(0);
    // Illegal instruction with a late flush_ack and a misaligned mtvec.
    ack_delay = 3; mtvec = 32'h203;
    exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hdead; exc_has_tval = 1;
    step(0);
    exc_valid = 0;
    repeat (8) step(0);
    // Timer interrupt.
    ack_delay = 0;
    irq_mtip = 1; mtie_en = 1; mie = 1; retire_valid = 1; next_pc = 32'h44;
    repeat (6) step(0);
    retire_valid = 0; irq_mtip = 0;
    repeat (6) step(0);
    // Priority: all three pending, then only MSI and MTI.
    {irq_msip, irq_mtip, irq_meip} = 3'b111; {msie_en, mtie_en, meie_en} = 3'b111;
    step(0); step(0);
    retire_valid = 1;
    step(0);
    retire_valid = 0; irq_meip = 0;
    repeat (6) step(0);
    retire_valid = 1;
    step(0);
    retire_valid = 0; {irq_msip, irq_mtip} = 2'b00;
    repeat (6) step(0);
    // Masking by mstatus.MIE.
    mie = 0; irq_mtip = 1; retire_valid = 1;
    repeat (20) step(0);
    mie = 1;
    step(0);
    retire_valid = 0; irq_mtip = 0;
    repeat (6) step(0);
    // Exception wins over MRET; then a standalone MRET.
    exc_valid = 1; mret = 1; exc_cause = 4'd11; exc_pc = 32'h300; exc_has_tval = 0;
    step(0);
    exc_valid = 0; mret = 0;
    repeat (6) step(0);
    mepc = 32'h80; mret = 1;
    step(0);
    mret = 0;
    repeat (3) step(0);
    ack_delay = -1;
    repeat (3000) step(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
